prime_check: RTL

PRIME_CHECK -- requirements
Module: prime_check

---
 rtl/prime_pkg.sv | 27 ++
 rtl/prime_div.sv | 87 ++++++++
 rtl/prime_check.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/prime_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : prime_pkg                                                       |
// | Purpose  : Shared constants and state encoding for the prime blocks        |
// |            (prime_check and primegen).                                     |
// | Contents : PRIME_W    - default operand/result width                       |
// |            DIV_CYCLES - cycles taken by one restoring divide               |
// |            state_t    - prime_check controller states                      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package prime_pkg;

    localparam int PRIME_W    = 16;
    // One quotient bit is resolved per cycle, so a divide takes one cycle per
    // dividend bit.
    localparam int DIV_CYCLES = PRIME_W;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        INIT  = 3'd1,
        CHECK = 3'd2,
        DIV   = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage : prime_pkg
`default_nettype wire

// File: rtl/prime_div.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : prime_div                                                       |
// | Purpose  : Restoring shift-subtract divider producing only the remainder.  |
// | Ports    : clk      - clock                                                |
// |            rst      - asynchronous reset, active low                       |
// |            start    - pulse: load dividend/divisor and begin               |
// |            dividend - value being divided                                  |
// |            divisor  - non-zero divisor                                     |
// |            rem      - remainder, valid while done=1                        |
// |            done     - one-cycle pulse STEPS cycles after start             |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module prime_div
    import prime_pkg::*;
#(
    parameter int W     = PRIME_W,
    parameter int STEPS = DIV_CYCLES
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] rem,
    output logic         done
);

    localparam int CNT_W = $clog2(STEPS + 1);

    logic [W-1:0]     r_rem;
    logic [W-1:0]     r_q;      // dividend bits still to be shifted in
    logic [W-1:0]     r_dvs;
    logic [CNT_W-1:0] r_cnt;    // iterations already performed
    logic             r_busy;

    logic [W-1:0]     w_rem_in;
    logic [W-1:0]     w_q_in;
    logic [W-1:0]     w_dvs_in;
    logic [W:0]       w_shift;
    logic [W:0]       w_diff;
    logic [W-1:0]     w_rem_nxt;
    logic [W-1:0]     w_q_nxt;

    // The first iteration runs on the start edge itself, straight from the
    // input operands, so the final remainder is ready STEPS-1 edges later and
    // done can be seen by the controller on the STEPS-th edge after start.
    always_comb begin
        w_rem_in  = start ? '0       : r_rem;
        w_q_in    = start ? dividend : r_q;
        w_dvs_in  = start ? divisor  : r_dvs;
        w_shift   = {w_rem_in, w_q_in[W-1]};
        w_diff    = w_shift - {1'b0, w_dvs_in};
        // A clear borrow bit means the trial subtraction fits: keep it.
        w_rem_nxt = w_diff[W] ? w_shift[W-1:0] : w_diff[W-1:0];
        w_q_nxt   = {w_q_in[W-2:0], 1'b0};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rem  <= '0;
            r_q    <= '0;
            r_dvs  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (start) begin
            r_rem  <= w_rem_nxt;
            r_q    <= w_q_nxt;
            r_dvs  <= divisor;
            r_cnt  <= CNT_W'(1);
            r_busy <= 1'b1;
        end else if (r_busy) begin
            if (r_cnt != CNT_W'(STEPS)) begin
                r_rem <= w_rem_nxt;
                r_q   <= w_q_nxt;
                r_cnt <= r_cnt + CNT_W'(1);
            end else begin
                r_busy <= 1'b0;
            end
        end
    end

    assign rem  = r_rem;
    assign done = r_busy && (r_cnt == CNT_W'(STEPS));

endmodule : prime_div
`default_nettype wire

// File: rtl/prime_check.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : prime_check                                                     |
// | Purpose  : Trial-division primality test. Reports the smallest divisor    |
// |            >1 for composites, the candidate for primes (1 counts as       |
// |            prime), and an error for 0.                                     |
// | Ports    : clk      - clock                                                |
// |            rst      - asynchronous reset, active low                       |
// |            go       - request, taken on an edge where ready=1              |
// |            a        - candidate, sampled with go                           |
// |            ready    - idle, results valid                                  |
// |            error    - last candidate was 0                                 |
// |            is_prime - last candidate was prime                             |
// |            res      - smallest divisor / candidate / 0                     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module prime_check
    import prime_pkg::*;
#(
    parameter int W = PRIME_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         go,
    input  logic [W-1:0] a,
    output logic         ready,
    output logic         error,
    output logic         is_prime,
    output logic [W-1:0] res
);

    // Trial divisors never pass sqrt(2^W)+1, so W/2+1 bits hold them and the
    // square needs twice that; for W=16 that is 9 and 18 bits.
    localparam int D_W  = W / 2 + 1;
    localparam int SQ_W = 2 * D_W;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [W-1:0]     r_n;
    logic [D_W-1:0]   r_d;
    logic             r_error;
    logic             r_is_prime;
    logic [W-1:0]     r_res;

    logic [SQ_W-1:0]  w_sq;
    logic             w_sq_gt_n;
    logic [W-1:0]     w_d_ext;
    logic             w_div_start;
    logic             w_div_done;
    logic [W-1:0]     w_div_rem;

    // Operands are zero-extended D_W-bit values, so this is a D_W x D_W
    // product carried at full width with no truncation.
    assign w_sq      = SQ_W'(r_d) * SQ_W'(r_d);
    assign w_sq_gt_n = w_sq > {{(SQ_W-W){1'b0}}, r_n};
    assign w_d_ext   = {{(W-D_W){1'b0}}, r_d};

    prime_div #(
        .W     (W),
        .STEPS (W)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (w_div_start),
        .dividend (r_n),
        .divisor  (w_d_ext),
        .rem      (w_div_rem),
        .done     (w_div_done)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_div_start = 1'b0;
        case (r_state)
            IDLE: begin
                if (go) begin
                    w_state_nxt = INIT;
                end
            end
            INIT: begin
                w_state_nxt = (r_n == '0) ? DONE : CHECK;
            end
            CHECK: begin
                if (w_sq_gt_n) begin
                    w_state_nxt = DONE;
                end else begin
                    w_div_start = 1'b1;
                    w_state_nxt = DIV;
                end
            end
            DIV: begin
                if (w_div_done) begin
                    w_state_nxt = (w_div_rem == '0) ? DONE : CHECK;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // In DONE, r_d still holds the divisor that ended the search: it divides n
    // for a composite, and its square exceeds n for a prime (including n=1,
    // where d=2 is never tried). That alone classifies the result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_n        <= '0;
            r_d        <= '0;
            r_error    <= 1'b0;
            r_is_prime <= 1'b0;
            r_res      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (go) begin
                        r_n <= a;
                    end
                end
                INIT: begin
                    r_d <= D_W'(2);
                end
                DIV: begin
                    if (w_div_done && (w_div_rem != '0)) begin
                        r_d <= (r_d == D_W'(2)) ? D_W'(3) : r_d + D_W'(2);
                    end
                end
                DONE: begin
                    r_error    <= (r_n == '0);
                    r_is_prime <= (r_n != '0) && w_sq_gt_n;
                    if (r_n == '0) begin
                        r_res <= '0;
                    end else if (w_sq_gt_n) begin
                        r_res <= r_n;
                    end else begin
                        r_res <= w_d_ext;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign ready    = (r_state == IDLE);
    assign error    = r_error;
    assign is_prime = r_is_prime;
    assign res      = r_res;

endmodule : prime_check
`default_nettype wire
